// File: rtl/btb_pkg.sv
// Shared types and constants for the branch target buffer.
package btb_pkg;

    localparam int DEFAULT_ENTRY_BITS = 6;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // Tag is held zero-extended to 32 bits so the record is independent of ENTRY_BITS.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
        ctr_e        ctr;
    } btb_entry_t;

endpackage

// File: rtl/btb_sat_counter.sv
// 2-bit saturating taken/not-taken counter; only instantiated when BTB_BHT_EN is defined.
module btb_sat_counter
    import btb_pkg::*;
(
    input  ctr_e ctr,
    input  logic taken,
    output ctr_e ctrNext
);

    always_comb begin
        ctrNext = ctr;
        if (taken && ctr != ST) begin
            ctrNext = ctr_e'(ctr + 2'd1);
        end else if (!taken && ctr != SNT) begin
            ctrNext = ctr_e'(ctr - 2'd1);
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with resolved/mispredicted branch counters.
// Define BTB_BHT_EN to add a 2-bit saturating counter per entry; otherwise a hit predicts taken.
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int ENTRY_BITS = DEFAULT_ENTRY_BITS
) (
    input  logic        clk,
    input  logic        CpuRst,
    input  logic [31:0] PCF,
    output logic        PredictedF,
    output logic [31:0] PredictedTargetF,
    input  logic [31:0] PCE,
    input  logic        IsBranchE,
    input  logic        BranchE,
    input  logic [31:0] BranchTargetE,
    input  logic        PredictedE,
    input  logic        StallE,
    output logic [31:0] BranchCnt,
    output logic [31:0] MispredCnt
);

    localparam int ENTRIES  = 1 << ENTRY_BITS;
    localparam int TAG_BITS = 30 - ENTRY_BITS;

    logic                validQ  [ENTRIES];
    logic [TAG_BITS-1:0] tagQ    [ENTRIES];
    logic [31:0]         targetQ [ENTRIES];
`ifdef BTB_BHT_EN
    ctr_e                ctrQ    [ENTRIES];
    ctr_e                ctrNext;
`endif

    logic [31:0] branchCnt;
    logic [31:0] mispredCnt;

    logic [ENTRY_BITS-1:0] fIdx;
    logic [TAG_BITS-1:0]   fTag;
    logic [ENTRY_BITS-1:0] eIdx;
    logic [TAG_BITS-1:0]   eTag;
    logic                  fHit;
    logic                  eHit;
    logic                  updateEn;
    btb_entry_t            fEntry;
    logic                  unusedPcBits;

    assign fIdx = PCF[ENTRY_BITS+1:2];
    assign fTag = PCF[31:ENTRY_BITS+2];
    assign eIdx = PCE[ENTRY_BITS+1:2];
    assign eTag = PCE[31:ENTRY_BITS+2];
    assign unusedPcBits = ^{PCF[1:0], PCE[1:0]};

    // Lookup reads registered state only, so a same-cycle update is never bypassed.
    always_comb begin
        fEntry        = '0;
        fEntry.valid  = validQ[fIdx];
        fEntry.tag    = 32'(tagQ[fIdx]);
        fEntry.target = targetQ[fIdx];
`ifdef BTB_BHT_EN
        fEntry.ctr    = ctrQ[fIdx];
`else
        fEntry.ctr    = SNT;
`endif
    end

    assign fHit = fEntry.valid && (fEntry.tag == 32'(fTag));
    assign eHit = validQ[eIdx] && (tagQ[eIdx] == eTag);

`ifdef BTB_BHT_EN
    assign PredictedF = fHit && fEntry.ctr[1];

    btb_sat_counter u_sat_counter (
        .ctr     (ctrQ[eIdx]),
        .taken   (BranchE),
        .ctrNext (ctrNext)
    );
`else
    logic unusedCtr;
    assign unusedCtr  = ^fEntry.ctr;
    assign PredictedF = fHit;
`endif

    assign PredictedTargetF = PredictedF ? fEntry.target : 32'h0;
    assign updateEn         = IsBranchE && !StallE;

    // Reset takes priority; a held stall defers the single update to the cycle it drops.
    always_ff @(posedge clk) begin
        if (CpuRst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                validQ[i]  <= 1'b0;
                tagQ[i]    <= '0;
                targetQ[i] <= '0;
`ifdef BTB_BHT_EN
                ctrQ[i]    <= SNT;
`endif
            end
            branchCnt  <= '0;
            mispredCnt <= '0;
        end else if (updateEn) begin
            branchCnt <= branchCnt + 32'd1;
            if (PredictedE != BranchE) begin
                mispredCnt <= mispredCnt + 32'd1;
            end
            if (eHit) begin
                if (BranchE) begin
                    targetQ[eIdx] <= BranchTargetE;
                end
`ifdef BTB_BHT_EN
                ctrQ[eIdx] <= ctrNext;
`else
                if (!BranchE) begin
                    validQ[eIdx] <= 1'b0;
                end
`endif
            end else if (BranchE) begin
                validQ[eIdx]  <= 1'b1;
                tagQ[eIdx]    <= eTag;
                targetQ[eIdx] <= BranchTargetE;
`ifdef BTB_BHT_EN
                ctrQ[eIdx]    <= WT;
`endif
            end
        end
    end

    assign BranchCnt  = branchCnt;
    assign MispredCnt = mispredCnt;

endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter ENTRY_BITS, 6, log2 of the entry count (64 entries, direct-mapped).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port CpuRst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port PCF  input  32  fetch-stage PC used for lookup.
REQ-005 SHALL have port PredictedF  output  1  predict taken for PCF; the pipeline carries it to EX, where the hazard unit receives it as PredictedE.
REQ-006 SHALL have port PredictedTargetF  output  32  predicted target for PCF; 0 when PredictedF=0.
REQ-007 SHALL have port PCE  input  32  EX-stage PC of the resolving instruction.
REQ-008 SHALL have port IsBranchE  input  1  EX instruction is a conditional branch.
REQ-009 SHALL have port BranchE  input  1  actual branch outcome (1 = taken).
REQ-010 SHALL have port BranchTargetE  input  32  resolved branch target.
REQ-011 SHALL have port PredictedE  input  1  prediction originally made for the EX instruction.
REQ-012 SHALL have port StallE  input  1  EX stage stalled; suppresses update.
REQ-013 SHALL have port BranchCnt  output  32  count of resolved branches.
REQ-014 SHALL have port MispredCnt  output  32  count of mispredicted branches.

Function
REQ-015 SHALL derive index = PC[ENTRY_BITS+1:2] and tag = PC[31:ENTRY_BITS+2].
REQ-016 SHALL compute the lookup combinationally from registered table state: hit = valid[idx] && tag[idx] == tag(PCF).
REQ-017 SHALL require an update event: IsBranchE && !StallE && !CpuRst; the table SHALL change only at a clock edge where an update event occurs.
REQ-018 SHALL, on an update event, if PCE hits and BranchE=1, write the target to BranchTargetE.
REQ-019 SHALL, on an update event, if PCE misses and BranchE=1, allocate the entry: valid=1, tag, target, counter=2'b10; this overwrites any previous occupant of the index.
REQ-020 SHALL, on an update event, if PCE misses and BranchE=0, leave the table unchanged.
REQ-021 SHALL, when a lookup and an update target the same index in the same cycle, return the pre-update contents to the lookup (no bypass).
REQ-022 SHALL, on each update event, increment BranchCnt by 1, and increment MispredCnt by 1 when PredictedE != BranchE.
REQ-023 SHALL wrap both 32-bit counters modulo 2^32 without saturation.
REQ-024 SHALL keep a StallE held over many cycles (cache miss) to exactly one update per branch, taken on the cycle StallE drops.

Reset
REQ-025 SHALL, on CpuRst at a clock edge, clear every valid bit, counter, tag and target to 0.
REQ-026 SHALL, on CpuRst at a clock edge, clear BranchCnt and MispredCnt to 0.
REQ-027 SHALL give CpuRst priority over a simultaneous update event; the update is discarded.
REQ-028 SHALL hold PredictedF=0 and PredictedTargetF=0 in the cycle after reset, for any PCF.

Configuration
REQ-029 SHALL provide macro BTB_BHT_EN to select the prediction policy.
REQ-030 SHALL, with BTB_BHT_EN defined, keep a 2-bit saturating counter per entry, set PredictedF = hit && counter[1], and on a hit update increment on taken and decrement on not-taken, saturating at 2'b11 and 2'b00.
REQ-031 SHALL, without BTB_BHT_EN, omit counter storage, set PredictedF = hit, and clear valid when a hit update has BranchE=0.

Structure
REQ-032 SHALL place in shared package btb_pkg: ENTRY_BITS default, counter encodings SNT=00, WNT=01, WT=10, ST=11, and the entry record typedef (valid, tag, target, counter).
REQ-033 SHALL implement the counter update in one sub-module, btb_sat_counter (2-bit in, taken in, 2-bit out), instantiated only under BTB_BHT_EN.

Verification
REQ-034 SHALL cover cold miss: after reset, PCF=0x100 -> PredictedF=0; then update PCE=0x100 taken, target 0x80 -> next cycle PCF=0x100 gives PredictedF=1, PredictedTargetF=0x80; BranchCnt=1, MispredCnt=1.
REQ-035 SHALL cover hysteresis (BTB_BHT_EN): entry at 2'b10, one not-taken -> PredictedF=0; one taken -> PredictedF=1; three taken -> 2'b11; one not-taken -> still PredictedF=1.
REQ-036 SHALL cover aliasing: PCE=0x100 and PCE=0x200 share index 0 with different tags; allocating 0x200 -> lookup of 0x100 misses.
REQ-037 SHALL cover the stall: IsBranchE=1 with StallE=1 for 5 cycles, then 0 -> BranchCnt advances by exactly 1.
REQ-038 SHALL cover reset priority: CpuRst=1 together with a taken update of 0x40 -> all lookups miss and both counters read 0.
REQ-039 SHALL cover wrap: force BranchCnt=0xFFFFFFFF, one update -> 0x00000000.
